// File: rtl/pipe_stage_buf_pkg.sv
// Shared types and constants for the inter-stage pipeline register:
// stall bus shape, enable/stop encodings and the buffer state encoding.
package pipe_stage_buf_pkg;

   localparam int STALL_W = 6;
   typedef logic [STALL_W-1:0] stall_bus_t;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;
   localparam logic NO_STOP = 1'b0;
   localparam logic STOP    = 1'b1;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;

   // Number of entries held in a given state.
   function automatic logic [1:0] occupancy_of(state_t s);
      case (s)
         ST_FULL: occupancy_of = 2'd1;
         ST_SKID: occupancy_of = 2'd2;
         default: occupancy_of = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// valid/ready/data bundle for one side of a pipeline boundary.
// A transfer happens on a rising edge where valid and ready are both 1;
// the master holds data stable while valid=1 and ready=0.
interface pipe_stage_buf_if #(
   parameter int WIDTH = 140
);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport master (output valid, output data, input  ready);
   modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/pipe_stage_buf_pipe_slot.sv
// One payload register: clear beats load, async active-low reset
// and clear both restore the bubble value.
module pipe_slot #(
   parameter int               WIDTH     = 140,
   parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_i,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (clr_i) begin
         data_d = NOP_VALUE;
      end else if (ld_i) begin
         data_d = d_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q <= NOP_VALUE;
      end else begin
         data_q <= data_d;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready, stall hold, flush and an
// optional skid entry that keeps upstream ready a pure function of state.
module pipe_stage_buf
   import pipe_stage_buf_pkg::*;
#(
   parameter int               WIDTH     = 140,
   parameter logic [WIDTH-1:0] NOP_VALUE = '0,
   parameter int               STALL_BIT = 3,
   parameter bit               SKID_EN   = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  stall_bus_t       stall,
   input  logic             flush,
   pipe_stage_buf_if.slave  up_if,
   pipe_stage_buf_if.master dn_if,
   output logic [1:0]       occupancy,
   output state_t           state_o
);

   state_t           state_q;
   state_t           state_d;
   logic             hold;
   logic             adv;
   logic             in_ready;
   logic             accept;
   logic             main_ld;
   logic             main_clr;
   logic             main_from_skid;
   logic             skid_ld;
   logic             skid_clr;
   logic [WIDTH-1:0] main_d;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic             unused_stall;

   assign hold     = stall[STALL_BIT] | ~dn_if.ready;
   assign adv      = ~hold;
   assign in_ready = SKID_EN ? (state_q != ST_SKID) : adv;
   assign accept   = up_if.valid & in_ready;

   assign unused_stall = ^stall;

   always_comb begin
      state_d        = state_q;
      main_ld        = 1'b0;
      main_clr       = 1'b0;
      main_from_skid = 1'b0;
      skid_ld        = 1'b0;
      skid_clr       = 1'b0;
      if (flush) begin
         // Flush overrides stall and drops anything offered this cycle.
         state_d  = ST_EMPTY;
         main_clr = 1'b1;
         skid_clr = 1'b1;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  main_ld = 1'b1;
                  state_d = ST_FULL;
               end
            end
            ST_FULL: begin
               if (accept && adv) begin
                  main_ld = 1'b1;
               end else if (SKID_EN && accept && hold) begin
                  skid_ld = 1'b1;
                  state_d = ST_SKID;
               end else if (adv) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_SKID: begin
               if (adv) begin
                  main_ld        = 1'b1;
                  main_from_skid = 1'b1;
                  skid_clr       = 1'b1;
                  state_d        = ST_FULL;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   assign main_d = main_from_skid ? skid_q : up_if.data;

   pipe_slot #(.WIDTH(WIDTH), .NOP_VALUE(NOP_VALUE)) u_main (
      .clk   (clk),
      .rst   (rst),
      .ld_i  (main_ld),
      .clr_i (main_clr),
      .d_i   (main_d),
      .q_o   (main_q)
   );

   generate
      if (SKID_EN) begin : g_skid
         pipe_slot #(.WIDTH(WIDTH), .NOP_VALUE(NOP_VALUE)) u_skid (
            .clk   (clk),
            .rst   (rst),
            .ld_i  (skid_ld),
            .clr_i (skid_clr),
            .d_i   (up_if.data),
            .q_o   (skid_q)
         );
      end else begin : g_no_skid
         logic unused_skid;
         assign unused_skid = skid_ld | skid_clr;
         assign skid_q      = NOP_VALUE;
      end
   endgenerate

   assign up_if.ready = in_ready;
   assign dn_if.valid = (state_q != ST_EMPTY);
   // Downstream always sees an explicit bubble, never stale payload.
   assign dn_if.data  = (state_q != ST_EMPTY) ? main_q : NOP_VALUE;
   assign occupancy   = occupancy_of(state_q);
   assign state_o     = state_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: one skid-enabled and one single-entry
// instance sharing clock, reset, stall and flush.
module tb_pipe_stage_buf;
   import pipe_stage_buf_pkg::*;

   localparam int               W   = 16;
   localparam logic [W-1:0]     NOP = 16'hBEEF;

   logic       clk;
   logic       rst;
   stall_bus_t stall;
   logic       flush;
   logic [1:0] occ1, occ0;
   state_t     st1, st0;
   int         vectors;
   int         miscompares;

   pipe_stage_buf_if #(.WIDTH(W)) u1_if ();
   pipe_stage_buf_if #(.WIDTH(W)) d1_if ();
   pipe_stage_buf_if #(.WIDTH(W)) u0_if ();
   pipe_stage_buf_if #(.WIDTH(W)) d0_if ();

   pipe_stage_buf #(.WIDTH(W), .NOP_VALUE(NOP), .STALL_BIT(3), .SKID_EN(1'b1)) dut_skid (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .up_if(u1_if), .dn_if(d1_if), .occupancy(occ1), .state_o(st1)
   );

   pipe_stage_buf #(.WIDTH(W), .NOP_VALUE(NOP), .STALL_BIT(3), .SKID_EN(1'b0)) dut_single (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .up_if(u0_if), .dn_if(d0_if), .occupancy(occ0), .state_o(st0)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall       = '0;
      flush       = 1'b0;
      u1_if.valid = 1'b0;
      u1_if.data  = '0;
      d1_if.ready = 1'b1;
      u0_if.valid = 1'b0;
      u0_if.data  = '0;
      d0_if.ready = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst         = 1'b0;
      u1_if.valid = 1'b1;
      u1_if.data  = 16'h00A5;
      #1;
      vectors++; if (d1_if.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", d1_if.valid); end
      vectors++; if (d1_if.data !== NOP) begin miscompares++; $display("FAIL reset_data got=%h exp=%h", d1_if.data, NOP); end
      vectors++; if (occ1 !== 2'd0) begin miscompares++; $display("FAIL reset_occ got=%0d exp=0", occ1); end
      vectors++; if (u1_if.ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", u1_if.ready); end
      step();
      step();
      vectors++; if (d1_if.valid !== 1'b0 || d1_if.data !== NOP) begin miscompares++; $display("FAIL reset_held got=%b/%h exp=0/%h", d1_if.valid, d1_if.data, NOP); end
      vectors++; if (d0_if.valid !== 1'b0 || occ0 !== 2'd0) begin miscompares++; $display("FAIL reset_single got=%b/%0d exp=0/0", d0_if.valid, occ0); end
      u1_if.valid = 1'b0;
      rst         = 1'b1;
      step();
   endtask

   task automatic test_streaming();
      for (int i = 1; i <= 4; i++) begin
         u1_if.valid = 1'b1;
         u1_if.data  = W'(i);
         #1;
         vectors++; if (u1_if.ready !== 1'b1) begin miscompares++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, u1_if.ready); end
         step();
         vectors++; if (d1_if.valid !== 1'b1 || d1_if.data !== W'(i)) begin miscompares++; $display("FAIL stream_out[%0d] got=%b/%h exp=1/%h", i, d1_if.valid, d1_if.data, W'(i)); end
      end
      u1_if.valid = 1'b0;
      step();
      vectors++; if (d1_if.valid !== 1'b0 || d1_if.data !== NOP || occ1 !== 2'd0) begin miscompares++; $display("FAIL stream_drain got=%b/%h/%0d exp=0/%h/0", d1_if.valid, d1_if.data, occ1, NOP); end
   endtask

   task automatic test_skid();
      u1_if.valid = 1'b1;
      u1_if.data  = 16'h0005;
      step();
      stall[3]   = 1'b1;
      u1_if.data = 16'h0006;
      #1;
      vectors++; if (u1_if.ready !== 1'b1) begin miscompares++; $display("FAIL skid_ready_full got=%b exp=1", u1_if.ready); end
      step();
      vectors++; if (occ1 !== 2'd2 || u1_if.ready !== 1'b0) begin miscompares++; $display("FAIL skid_enter got=%0d/%b exp=2/0", occ1, u1_if.ready); end
      vectors++; if (d1_if.data !== 16'h0005) begin miscompares++; $display("FAIL skid_out_hold got=%h exp=0005", d1_if.data); end
      // Offered while full-and-skid: must not be taken.
      u1_if.data = 16'h0077;
      step();
      vectors++; if (occ1 !== 2'd2 || d1_if.data !== 16'h0005) begin miscompares++; $display("FAIL skid_stay got=%0d/%h exp=2/0005", occ1, d1_if.data); end
      u1_if.valid = 1'b0;
      stall       = '0;
      step();
      vectors++; if (d1_if.data !== 16'h0006 || occ1 !== 2'd1 || u1_if.ready !== 1'b1) begin miscompares++; $display("FAIL skid_release got=%h/%0d/%b exp=0006/1/1", d1_if.data, occ1, u1_if.ready); end
      step();
      vectors++; if (occ1 !== 2'd0 || d1_if.valid !== 1'b0 || d1_if.data !== NOP) begin miscompares++; $display("FAIL skid_empty got=%0d/%b/%h exp=0/0/%h", occ1, d1_if.valid, d1_if.data, NOP); end
   endtask

   task automatic test_flush();
      d1_if.ready = 1'b0;
      u1_if.valid = 1'b1;
      u1_if.data  = 16'h0007;
      step();
      u1_if.data = 16'h0008;
      step();
      vectors++; if (occ1 !== 2'd2 || d1_if.data !== 16'h0007) begin miscompares++; $display("FAIL flush_setup got=%0d/%h exp=2/0007", occ1, d1_if.data); end
      flush      = 1'b1;
      stall[3]   = 1'b1;
      u1_if.data = 16'h0009;
      step();
      vectors++; if (d1_if.valid !== 1'b0 || d1_if.data !== NOP || occ1 !== 2'd0) begin miscompares++; $display("FAIL flush_kill got=%b/%h/%0d exp=0/%h/0", d1_if.valid, d1_if.data, occ1, NOP); end
      vectors++; if (u1_if.ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready got=%b exp=1", u1_if.ready); end
      flush       = 1'b0;
      stall       = '0;
      u1_if.valid = 1'b0;
      d1_if.ready = 1'b1;
      step();
      vectors++; if (d1_if.valid !== 1'b0 || occ1 !== 2'd0) begin miscompares++; $display("FAIL flush_no_leak got=%b/%0d exp=0/0", d1_if.valid, occ1); end
   endtask

   task automatic test_no_skid();
      u0_if.valid = 1'b1;
      u0_if.data  = 16'h0011;
      step();
      vectors++; if (d0_if.valid !== 1'b1 || d0_if.data !== 16'h0011) begin miscompares++; $display("FAIL single_load got=%b/%h exp=1/0011", d0_if.valid, d0_if.data); end
      stall[3]   = 1'b1;
      u0_if.data = 16'h0022;
      #1;
      vectors++; if (u0_if.ready !== 1'b0) begin miscompares++; $display("FAIL single_ready_comb got=%b exp=0", u0_if.ready); end
      step();
      vectors++; if (d0_if.data !== 16'h0011 || occ0 !== 2'd1) begin miscompares++; $display("FAIL single_hold got=%h/%0d exp=0011/1", d0_if.data, occ0); end
      stall = '0;
      #1;
      vectors++; if (u0_if.ready !== 1'b1) begin miscompares++; $display("FAIL single_ready_back got=%b exp=1", u0_if.ready); end
      step();
      vectors++; if (d0_if.valid !== 1'b1 || d0_if.data !== 16'h0022) begin miscompares++; $display("FAIL single_resume got=%b/%h exp=1/0022", d0_if.valid, d0_if.data); end
      u0_if.valid = 1'b0;
      step();
      vectors++; if (d0_if.valid !== 1'b0 || d0_if.data !== NOP || occ0 !== 2'd0) begin miscompares++; $display("FAIL single_drain got=%b/%h/%0d exp=0/%h/0", d0_if.valid, d0_if.data, occ0, NOP); end
   endtask

   task automatic test_async_reset();
      u1_if.valid = 1'b1;
      u1_if.data  = 16'h0031;
      step();
      stall[3]   = 1'b1;
      u1_if.data = 16'h0032;
      step();
      vectors++; if (occ1 !== 2'd2) begin miscompares++; $display("FAIL areset_setup got=%0d exp=2", occ1); end
      #2;
      rst = 1'b0;
      #1;
      vectors++; if (occ1 !== 2'd0 || d1_if.valid !== 1'b0 || d1_if.data !== NOP || u1_if.ready !== 1'b1) begin miscompares++; $display("FAIL areset_now got=%0d/%b/%h/%b exp=0/0/%h/1", occ1, d1_if.valid, d1_if.data, u1_if.ready, NOP); end
      u1_if.valid = 1'b0;
      stall       = '0;
      #1;
      rst = 1'b1;
      step();
      vectors++; if (d1_if.valid !== 1'b0 || d1_if.data !== NOP) begin miscompares++; $display("FAIL areset_no_survivor got=%b/%h exp=0/%h", d1_if.valid, d1_if.data, NOP); end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_streaming();
      test_skid();
      test_flush();
      test_no_skid();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
